// File: rtl/mem_pkg.sv
// Shared load/store path definitions: responder state encoding, memory opcodes
// and data word width, also consumed by the control unit.
package mem_pkg;

    localparam int WORD_W = 32;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/sram_1p.sv
// Synchronous single-port word array; registered read port, contents not reset.
module sram_1p #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Array write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read register holds its value until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: word access with fixed wait states on an
// internal single-port array, stalling the pipeline until completion.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic        Err
);

    localparam int  IDX_W   = $clog2(DEPTH);
    localparam int  CNT_W   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam bit  NO_WAIT = (WAIT_STATES == 0);

    mem_state_t          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                wr_q;
    logic                done_q;
    logic                err_q;

    logic                req_any_s;
    logic                legal_s;
    logic                fire_s;
    logic                mem_we_s;
    logic                mem_re_s;
    logic [IDX_W-1:0]    mem_addr_s;
    logic [WORD_W-1:0]   mem_wdata_s;
    logic                addr_unused_s;

    assign addr_unused_s = ^Addr[31:IDX_W+2];

    // Request decode and array strobes; the array is touched only on entry to RESP
    always_comb begin
        req_any_s   = MemRead | MemWrite;
        legal_s     = (MemRead ^ MemWrite) && (Addr[1:0] == 2'b00);
        fire_s      = 1'b0;
        mem_addr_s  = addr_q;
        mem_wdata_s = wdata_q;
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        case (state_q)
            IDLE: begin
                fire_s      = legal_s && NO_WAIT;
                mem_addr_s  = Addr[IDX_W+1:2];
                mem_wdata_s = WriteData;
                mem_we_s    = rst_n & fire_s & MemWrite;
                mem_re_s    = rst_n & fire_s & MemRead;
            end
            WAIT: begin
                fire_s   = (cnt_q <= CNT_W'(1));
                mem_we_s = rst_n & fire_s & wr_q;
                mem_re_s = rst_n & fire_s & ~wr_q;
            end
            RESP: begin
                fire_s = 1'b0;
            end
            default: begin
                fire_s = 1'b0;
            end
        endcase
        Stall = rst_n & (((state_q == IDLE) && legal_s) || (state_q == WAIT));
    end

    // Access sequencer with registered completion and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (legal_s) begin
                        addr_q  <= Addr[IDX_W+1:2];
                        wdata_q <= WriteData;
                        wr_q    <= MemWrite;
                        cnt_q   <= CNT_W'(WAIT_STATES);
                        if (NO_WAIT) begin
                            state_q <= RESP;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else if (req_any_s) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (fire_s) begin
                        cnt_q   <= '0;
                        state_q <= RESP;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Done = done_q;
    assign Err  = err_q;

    sram_1p #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_sram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .addr  (mem_addr_s),
        .wdata (mem_wdata_s),
        .rdata (ReadData)
    );

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder side of the load/store control path. It accepts the `MemRead`/`MemWrite` strobes raised by the decode stage for load (`0000011`) and store (`0100011`) instructions, performs a word access with a configurable wait-state count on an internal single-port array, and holds the pipeline with `Stall` until the access completes. It sits in the MEM stage, between the ALU result/rs2 path and the `MemtoReg` writeback mux.

## Interface
**Parameters**
- `DEPTH`, 256: number of 32-bit words; must be a power of two.
- `WAIT_STATES`, 2: extra cycles per access; 0 is legal.

**Ports**
- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `MemRead`  in  1  load request from control.
- `MemWrite`  in  1  store request from control.
- `Addr`  in  32  byte address (ALU result).
- `WriteData`  in  32  store data (rs2).
- `ReadData`  out  32  load result; registered.
- `Stall`  out  1  freeze PC and pipeline registers.
- `Done`  out  1  one-cycle completion pulse.
- `Err`  out  1  one-cycle pulse on an illegal request.

## Operation
- States: `IDLE`, `WAIT`, `RESP`.
- A legal request has exactly one of `MemRead`/`MemWrite` high and `Addr[1:0]==2'b00`.
- **IDLE**
  - Legal request: latch `Addr`, `WriteData` and the read/write direction. Load the wait counter with `WAIT_STATES`. Go to `WAIT`, or straight to `RESP` when `WAIT_STATES==0`.
  - Illegal request (both strobes high, or misaligned): pulse `Err` on the next cycle. No array access, no stall, stay `IDLE`.
- **WAIT**
  - Counter decrements each cycle. At 0, go to `RESP`.
  - On the transition into `RESP`:
    - a write commits to `mem[Addr[$clog2(DEPTH)+1:2]]`;
    - a read loads `ReadData`.
- **RESP**
  - `Done`=1 and `Stall`=0. Inputs are ignored because they still belong to the completing instruction.
  - Always returns to `IDLE`.
- Address index uses only `Addr[$clog2(DEPTH)+1:2]`; upper bits are ignored, so addresses wrap modulo `DEPTH` words.
- `ReadData` holds its value until the next read completes. Writes do not change it.
- Inputs change in `WAIT` are ignored because the latched copy is used. The pipeline holds them stable while `Stall` is high.

## Timing
- `Stall` is combinational: `(state==IDLE && legal request) || state==WAIT`. It is high in the very cycle the request first appears.
- A request first presented in cycle N stalls cycles N..N+`WAIT_STATES`. `Done` and valid `ReadData` appear in cycle N+1+`WAIT_STATES`.
- Back-to-back requests: the next request is accepted in the `IDLE` cycle after `RESP`. Minimum period is 2+`WAIT_STATES` cycles.
- Reset values: state `IDLE`, counter 0, `ReadData`=0, `Done`=0, `Err`=0. `Stall` is forced 0 while `rst_n`=0.
- Array contents are not reset.
- Reset mid-access aborts the access. A write that has not yet entered `RESP` is never committed.

## Structure
- Shared package `mem_pkg`:
  - `mem_state_t` enum (`IDLE`/`WAIT`/`RESP`);
  - opcode constants `OP_LOAD`=7'b0000011 and `OP_STORE`=7'b0100011, also consumed by the control unit;
  - `WORD_W`=32.
- One sub-module, `sram_1p`: a `DEPTH`×32 synchronous single-port array with `we`, `re`, `addr`, `wdata` and registered `rdata`. `data_mem_responder` drives it with `we`/`re` only on the transition into `RESP`.

## Test plan
- Store then load, `WAIT_STATES=2`: store 0xDEADBEEF to 0x10, then load 0x10.
  - Each access gives 3 stall cycles and `Done` in cycle N+3.
  - The load returns 0xDEADBEEF.
- `WAIT_STATES=0`: load from 0x04 after a store of 0x12345678.
  - 1 stall cycle, `Done` in N+1, `ReadData`=0x12345678.
- Misaligned and conflicting requests: `MemRead` with `Addr`=0x13, then `MemRead`=`MemWrite`=1.
  - Each gives an `Err` pulse, `Stall`=0 and no change to `ReadData` or the array.
- Wrap-around, `DEPTH=256`: store 0xA5A5A5A5 to 0x400, then load 0x000 → 0xA5A5A5A5.
- Reset mid-write: store 0x11111111 to 0x20, and drop `rst_n` during `WAIT`.
  - All outputs go to their reset values immediately.
  - A later load of 0x20 returns the prior contents, not 0x11111111.
- Input change during stall: alter `Addr` and `WriteData` in `WAIT`. The original latched address and data are the ones written.
